det3_seq: RTL and testbench

- Sequential, parametrised determinant engine for a packed 3x3 matrix of signed W-bit elements; also computes 2x2 determinants via a mode bit.
- Uses one shared signed multiplier and a valid/ready handshake on both input and output.
- Sits between the matrix register file and downstream solver/inverse logic; replaces the purely combinational single-width determinant.

---
 rtl/det_pkg.sv | 23 ++
 rtl/det_mac.sv | 40 ++++
 rtl/det3_seq.sv | 179 +++++++++++++++++
 tb/tb_det3_seq.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/det_pkg.sv
// Shared types, step limits and the packed-matrix element slicer for the determinant engine.
package det_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    typedef enum logic [1:0] {MAC_LOAD, MAC_SUB, MAC_ADD} mac_op_t;

    localparam int LAST_STEP_3X3 = 8;
    localparam int LAST_STEP_2X2 = 1;
    localparam int MAX_W         = 32;

    // Returns element a(r,c) of a row-major packed matrix, sign-extended to MAX_W bits.
    function automatic logic signed [MAX_W-1:0] elem(input logic [9*MAX_W-1:0] m,
                                                     input int r, input int c, input int w);
        logic [9*MAX_W-1:0]      sh;
        logic signed [MAX_W-1:0] v;
        sh = m >> ((8 - (3*r + c)) * w);
        v  = sh[MAX_W-1:0];
        v  = v <<< (MAX_W - w);
        v  = v >>> (MAX_W - w);
        return v;
    endfunction

endpackage

// File: rtl/det_mac.sv
// Signed W x (2W+1) multiply with load/sub/add into an ACC_W accumulator; one product per enabled cycle.
// acc_nxt exposes the value the accumulator takes on the coming edge so callers can capture it.
module det_mac
    import det_pkg::*;
#(
    parameter int W     = 4,
    parameter int ACC_W = 3*W+1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [1:0]              op,
    input  logic signed [W-1:0]     a,
    input  logic signed [2*W:0]     b,
    output logic signed [ACC_W-1:0] acc,
    output logic signed [ACC_W-1:0] acc_nxt
);

    logic signed [ACC_W-1:0] prod;

    assign prod = ACC_W'(a) * ACC_W'(b);

    always_comb begin
        acc_nxt = acc;
        if (en) begin
            case (op)
                MAC_LOAD: acc_nxt = prod;
                MAC_SUB:  acc_nxt = acc - prod;
                MAC_ADD:  acc_nxt = acc + prod;
                default:  acc_nxt = acc;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc <= '0;
        else        acc <= acc_nxt;
    end

endmodule

// File: rtl/det3_seq.sv
// Sequential 3x3 / 2x2 signed determinant, one shared multiplier; result 9 (3x3) or 2 (2x2) edges after accept,
// held in DONE until out_ready. DET_SAT_EN selects clamping (ovf=1) instead of wrapping on narrow OUT_W.
module det3_seq
    import det_pkg::*;
#(
    parameter int W     = 4,
    parameter int OUT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               mode_2x2,
    input  logic [9*W-1:0]     mat,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   det,
    output logic               ovf
);

    localparam int ACC_W = 3*W+1;
    localparam int B_W   = 2*W+1;

    state_t                  state_q, state_d;
    logic [3:0]              step_q, step_d;
    logic                    mode_q;
    logic [9*W-1:0]          mat_q;
    logic signed [B_W-1:0]   c0_q, c1_q, c2_q;
    logic signed [W-1:0]     a [3][3];
    logic [9*MAX_W-1:0]      mat_ext;
    logic signed [MAX_W-1:0] e;

    logic                    mac_en;
    logic [1:0]              mac_op;
    logic signed [W-1:0]     mul_a;
    logic signed [B_W-1:0]   mul_b;
    logic signed [ACC_W-1:0] acc, acc_nxt;
    logic                    last_step;
    logic [OUT_W-1:0]        det_nxt;
    logic                    ovf_nxt;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);

    always_comb begin
        mat_ext = '0;
        mat_ext[9*W-1:0] = mat_q;
        e = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                e = elem(mat_ext, r, c, W);
                a[r][c] = e[W-1:0];
            end
        end
    end

    det_mac #(.W(W), .ACC_W(ACC_W)) u_mac (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (mac_en),
        .op      (mac_op),
        .a       (mul_a),
        .b       (mul_b),
        .acc     (acc),
        .acc_nxt (acc_nxt)
    );

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        mac_en    = 1'b0;
        mac_op    = MAC_LOAD;
        mul_a     = '0;
        mul_b     = '0;
        last_step = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = CALC;
                    step_d  = '0;
                end
            end
            CALC: begin
                mac_en = 1'b1;
                if (mode_q) begin
                    last_step = (step_q == 4'(LAST_STEP_2X2));
                    if (step_q == 4'd0) begin
                        mul_a = a[0][0]; mul_b = B_W'(a[1][1]); mac_op = MAC_LOAD;
                    end else begin
                        mul_a = a[0][1]; mul_b = B_W'(a[1][0]); mac_op = MAC_SUB;
                    end
                end else begin
                    last_step = (step_q == 4'(LAST_STEP_3X3));
                    // Minors c0..c2 first, then the row-0 expansion reuses them as the wide operand.
                    case (step_q)
                        4'd0:    begin mul_a = a[1][1]; mul_b = B_W'(a[2][2]); mac_op = MAC_LOAD; end
                        4'd1:    begin mul_a = a[1][2]; mul_b = B_W'(a[2][1]); mac_op = MAC_SUB;  end
                        4'd2:    begin mul_a = a[1][0]; mul_b = B_W'(a[2][2]); mac_op = MAC_LOAD; end
                        4'd3:    begin mul_a = a[1][2]; mul_b = B_W'(a[2][0]); mac_op = MAC_SUB;  end
                        4'd4:    begin mul_a = a[1][0]; mul_b = B_W'(a[2][1]); mac_op = MAC_LOAD; end
                        4'd5:    begin mul_a = a[1][1]; mul_b = B_W'(a[2][0]); mac_op = MAC_SUB;  end
                        4'd6:    begin mul_a = a[0][0]; mul_b = c0_q;          mac_op = MAC_LOAD; end
                        4'd7:    begin mul_a = a[0][1]; mul_b = c1_q;          mac_op = MAC_SUB;  end
                        default: begin mul_a = a[0][2]; mul_b = c2_q;          mac_op = MAC_ADD;  end
                    endcase
                end
                if (last_step) state_d = DONE;
                else           step_d  = step_q + 4'd1;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= 1'b0;
            mat_q  <= '0;
            c0_q   <= '0;
            c1_q   <= '0;
            c2_q   <= '0;
            det    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                mode_q <= mode_2x2;
                mat_q  <= mat;
            end
            if (state_q == CALC && !mode_q) begin
                case (step_q)
                    4'd1:    c0_q <= acc_nxt[B_W-1:0];
                    4'd3:    c1_q <= acc_nxt[B_W-1:0];
                    4'd5:    c2_q <= acc_nxt[B_W-1:0];
                    default: ;
                endcase
            end
            if (state_q == CALC && last_step) begin
                det <= det_nxt;
                ovf <= ovf_nxt;
            end
        end
    end

    generate
        if (OUT_W < ACC_W) begin : g_narrow
`ifdef DET_SAT_EN
            logic [ACC_W-OUT_W:0] hi;
            assign hi = acc_nxt[ACC_W-1:OUT_W-1];
            // Out of range exactly when the bits above the OUT_W sign bit are not a pure sign extension.
            always_comb begin
                ovf_nxt = !((&hi) || !(|hi));
                if (ovf_nxt)
                    det_nxt = acc_nxt[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
                else
                    det_nxt = acc_nxt[OUT_W-1:0];
            end
`else
            assign det_nxt = acc_nxt[OUT_W-1:0];
            assign ovf_nxt = 1'b0;
`endif
        end else begin : g_wide
            assign det_nxt = OUT_W'(acc_nxt);
            assign ovf_nxt = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_det3_seq.sv
// Bench for det3_seq: directed table, handshake corner sequences and random matrices against an arithmetic model.
module tb_det3_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        mode_2x2 = 1'b0;
    logic        out_ready = 1'b1;
    logic [35:0] mat = '0;

    logic        in_ready0, in_ready1, out_valid0, out_valid1, ovf0, ovf1;
    logic [15:0] det0;
    logic [7:0]  det1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    det3_seq #(.W(4), .OUT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .mode_2x2(mode_2x2), .mat(mat), .out_valid(out_valid0), .out_ready(out_ready),
        .det(det0), .ovf(ovf0)
    );

    det3_seq #(.W(4), .OUT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .mode_2x2(mode_2x2), .mat(mat), .out_valid(out_valid1), .out_ready(out_ready),
        .det(det1), .ovf(ovf1)
    );

    typedef struct {
        logic   md;
        int     m[9];
        longint exp16;
        longint exp8;
        longint eovf8;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [35:0] pack(input int m[9]);
        logic [35:0] p;
        p = '0;
        for (int i = 0; i < 9; i++) p[(8-i)*4 +: 4] = 4'(m[i]);
        return p;
    endfunction

    function automatic longint model(input logic md, input int m[9]);
        if (md) return longint'(m[0]*m[4] - m[1]*m[3]);
        return longint'(m[0]*(m[4]*m[8] - m[5]*m[7]) - m[1]*(m[3]*m[8] - m[5]*m[6])
                        + m[2]*(m[3]*m[7] - m[4]*m[6]));
    endfunction

    function automatic longint red8(input longint v);
`ifdef DET_SAT_EN
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
`else
        longint t;
        t = v & 255;
        if (t > 127) t = t - 256;
        return t;
`endif
    endfunction

    function automatic longint ovf8(input longint v);
`ifdef DET_SAT_EN
        return (v > 127 || v < -128) ? 1 : 0;
`else
        return (v == v + 1) ? 1 : 0;
`endif
    endfunction

    // Presents one matrix, waits for the accepting edge, then counts edges until out_valid.
    task automatic apply(input logic md, input int m[9], output int lat);
        @(negedge clk);
        mode_2x2 = md;
        mat      = pack(m);
        in_valid = 1'b1;
        check("in_ready_before_accept", longint'(in_ready0 & in_ready1), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mode_2x2 = 1'($urandom);
        mat      = 36'({$urandom, $urandom});
        lat = 0;
        while (!out_valid0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("out_valid_agree", longint'(out_valid1), longint'(out_valid0));
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
        check("out_valid_drop", longint'(out_valid0 | out_valid1), 0);
        check("back_to_idle", longint'(in_ready0 & in_ready1), 1);
    endtask

    vec_t   vt[4];
    int     lat;
    int     ident[9];
    int     rm[9];
    logic   rmd;
    longint ex;
    int     stale;

    initial begin
        ident = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
        vt[0].md = 1'b0; vt[0].m = ident;                          vt[0].exp16 = 1;    vt[0].exp8 = 1;   vt[0].eovf8 = 0;
        vt[1].md = 1'b0; vt[1].m = '{2, -3, 1, 2, 0, -1, 1, 4, 5}; vt[1].exp16 = 49;   vt[1].exp8 = 49;  vt[1].eovf8 = 0;
        vt[2].md = 1'b0; vt[2].m = '{-8, 7, 0, 0, -8, 7, 7, 0, -8}; vt[2].exp16 = -169;
`ifdef DET_SAT_EN
        vt[2].exp8 = -128; vt[2].eovf8 = 1;
`else
        vt[2].exp8 = 87;   vt[2].eovf8 = 0;
`endif
        vt[3].md = 1'b1; vt[3].m = '{-8, -8, 5, 7, -8, -3, 6, -1, 2}; vt[3].exp16 = 120; vt[3].exp8 = 120; vt[3].eovf8 = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", longint'(out_valid0 | out_valid1), 0);
        check("rst_det", longint'(det0), 0);
        check("rst_ovf", longint'(ovf0 | ovf1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready0 & in_ready1), 1);

        for (int i = 0; i < 4; i++) begin
            apply(vt[i].md, vt[i].m, lat);
            check("vec_latency", lat, vt[i].md ? 2 : 9);
            check("vec_det16", longint'($signed(det0)), vt[i].exp16);
            check("vec_ovf16", longint'(ovf0), 0);
            check("vec_det8", longint'($signed(det1)), vt[i].exp8);
            check("vec_ovf8", longint'(ovf1), vt[i].eovf8);
            consume();
        end

        // Backpressure: result must hold while new inputs are refused.
        out_ready = 1'b0;
        apply(1'b0, vt[1].m, lat);
        check("bp_latency", lat, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            mat      = pack(ident);
            @(posedge clk);
            #1;
            check("bp_out_valid", longint'(out_valid0), 1);
            check("bp_det", longint'($signed(det0)), 49);
            check("bp_ovf", longint'(ovf0), 0);
            check("bp_in_ready", longint'(in_ready0), 0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        consume();
        apply(1'b0, ident, lat);
        check("bp_next_det", longint'($signed(det0)), 1);
        consume();

        // Asynchronous reset in the middle of a 3x3 run.
        apply(1'b0, vt[2].m, lat);
        consume();
        @(negedge clk);
        mode_2x2 = 1'b0;
        mat      = pack(vt[1].m);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", longint'(out_valid0 | out_valid1), 0);
        check("midrst_det", longint'(det0), 0);
        check("midrst_det8", longint'(det1), 0);
        check("midrst_ovf", longint'(ovf0 | ovf1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (out_valid0 || out_valid1) stale++;
        end
        check("midrst_no_stale", stale, 0);
        apply(1'b0, ident, lat);
        check("midrst_ident_det", longint'($signed(det0)), 1);
        check("midrst_ident_lat", lat, 9);
        consume();

        for (int n = 0; n < 300; n++) begin
            rmd = 1'($urandom_range(1));
            for (int i = 0; i < 9; i++) rm[i] = int'($urandom_range(15)) - 8;
            ex = model(rmd, rm);
            apply(rmd, rm, lat);
            check("rnd_latency", lat, rmd ? 2 : 9);
            check("rnd_det16", longint'($signed(det0)), ex);
            check("rnd_ovf16", longint'(ovf0), 0);
            check("rnd_det8", longint'($signed(det1)), red8(ex));
            check("rnd_ovf8", longint'(ovf1), ovf8(ex));
            consume();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
